mem_req_adapter: RTL and testbench

MEM_REQ_ADAPTER -- requirements
Module: mem_req_adapter

---
 rtl/pdla_mem_pkg.sv | 23 ++
 rtl/mem_rsp_fifo.sv | 58 +++++
 rtl/mem_req_adapter.sv | 86 ++++++++
 tb/tb_mem_req_adapter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdla_mem_pkg.sv
// Shared types and defaults for the memory request adapter and its response buffer.
package pdla_mem_pkg;

  localparam int unsigned RESP_DEPTH_DEF = 2;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } mem_op_e;

  // Field view of a request/response at the default 12-bit address, 32-bit data geometry.
  typedef struct packed {
    mem_op_e     op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
  } mem_rsp_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous read-response FIFO with occupancy count; push when full and pop when empty are ignored.
module mem_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the cleared count makes stale entries unreachable.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mem_req_adapter.sv
// Valid/ready request port to single-port synchronous SRAM, with a buffered in-order read response.
module mem_req_adapter
  import pdla_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned RESP_DEPTH = RESP_DEPTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_initn,
  output logic                  mem_cen,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_d,
  output logic [BE_WIDTH-1:0]   mem_ben,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);

  logic            r_initn;
  logic            r_rd_pending;
  logic            w_is_write;
  logic            w_accept;
  logic            w_pop;
  logic            w_empty;
  logic            w_rd_room;
  logic [CntW-1:0] w_count;
  logic [CntW:0]   w_occ_next;

  assign w_is_write = (mem_op_e'(req_we) == OpWrite);
  assign w_pop      = !w_empty && rsp_ready;

  // A read in flight already owns a FIFO slot; a same-cycle pop frees one.
  assign w_occ_next = {1'b0, w_count} + {{CntW{1'b0}}, r_rd_pending} - {{CntW{1'b0}}, w_pop};
  assign w_rd_room  = w_occ_next < (CntW + 1)'(RESP_DEPTH);

  assign req_ready = r_initn && (w_is_write || w_rd_room);
  assign w_accept  = req_valid && req_ready;

  assign mem_initn = r_initn;
  assign mem_cen   = ~w_accept;
  assign mem_wen   = ~req_we;
  assign mem_a     = req_addr;
  assign mem_d     = req_wdata;
  assign mem_ben   = w_is_write ? ~req_be : '1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_initn      <= 1'b0;
      r_rd_pending <= 1'b0;
    end else begin
      r_initn      <= 1'b1;
      r_rd_pending <= w_accept && !w_is_write;
    end
  end

  mem_rsp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_WIDTH),
    .CNT_W (CntW)
  ) u_rsp_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (r_rd_pending),
    .i_wdata (mem_q),
    .i_pop   (w_pop),
    .o_rdata (rsp_rdata),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign rsp_valid = !w_empty;

endmodule

// File: tb/tb_mem_req_adapter.sv
// Bench for mem_req_adapter: SRAM model, vector table for port mapping, scoreboard for read data.
module tb_mem_req_adapter;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        mem_initn;
  logic        mem_cen;
  logic        mem_wen;
  logic [11:0] mem_a;
  logic [31:0] mem_d;
  logic [3:0]  mem_ben;
  logic [31:0] mem_q;

  mem_req_adapter dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_initn (mem_initn),
    .mem_cen   (mem_cen),
    .mem_wen   (mem_wen),
    .mem_a     (mem_a),
    .mem_d     (mem_d),
    .mem_ben   (mem_ben),
    .mem_q     (mem_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] pat(input logic [11:0] a);
    return {8'h5A, a, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Synchronous SRAM: active-low enables, registered read data.
  logic [31:0] sram [int];
  always @(posedge CLK) begin
    if (!mem_cen) begin
      if (!mem_wen)
        sram[int'(mem_a)] = merge(sram.exists(int'(mem_a)) ? sram[int'(mem_a)] : pat(mem_a),
                                  mem_d, ~mem_ben);
      else
        mem_q <= sram.exists(int'(mem_a)) ? sram[int'(mem_a)] : pat(mem_a);
    end
  end

  typedef struct {
    logic [31:0] data;
    int          acc_cyc;
    logic        chk_lat;
  } sb_t;

  typedef struct {
    logic        v;
    logic        we;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        cen;
    logic        wen;
    logic [3:0]  ben;
    logic        rdy;
  } vec_t;

  sb_t         exp_q[$];
  logic [31:0] ref_mem [int];
  vec_t        vecs[8];
  int          n_tests;
  int          n_fail;
  int          cyc;
  logic        g_chk_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    sb_t e;
    logic [31:0] old;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got response %0h, required none (cycle %0d)", rsp_rdata, cyc);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 64'(rsp_rdata), 64'(e.data));
        if (e.chk_lat) check("sb_latency", 64'(cyc - e.acc_cyc), 64'(2));
      end
    end
    if (req_valid && req_ready) begin
      old = ref_mem.exists(int'(req_addr)) ? ref_mem[int'(req_addr)] : pat(req_addr);
      if (req_we) ref_mem[int'(req_addr)] = merge(old, req_wdata, req_be);
      else exp_q.push_back('{data: old, acc_cyc: cyc, chk_lat: g_chk_lat});
    end
  endtask

  task automatic to_neg();
    @(negedge CLK);
    monitor();
  endtask

  task automatic to_pos();
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(1'b1, 1'b1, a, d, be);
    to_neg();
    check("wr_ready", 64'(req_ready), 64'(1));
    to_pos();
    drive(1'b0, 1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic read_expect(input logic [11:0] a, input logic [31:0] exp, input string name);
    drive(1'b1, 1'b0, a, 32'h0, 4'h0);
    to_neg();
    check({name, "_ready"}, 64'(req_ready), 64'(1));
    to_pos();
    drive(1'b0, 1'b0, a, 32'h0, 4'h0);
    to_neg();
    check({name, "_early"}, 64'(rsp_valid), 64'(0));
    to_pos();
    to_neg();
    check({name, "_valid"}, 64'(rsp_valid), 64'(1));
    check({name, "_data"}, 64'(rsp_rdata), 64'(exp));
    to_pos();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    g_chk_lat = 1'b1;
    rsp_ready = 1'b1;
    RST       = 1'b1;
    drive(1'b1, 1'b0, 12'h003, 32'h0, 4'h0);

    vecs[0] = '{1'b0, 1'b0, 12'h100, 32'h00000000, 4'h0, 1'b1, 1'b1, 4'hF, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 12'h040, 32'h12345678, 4'hF, 1'b0, 1'b0, 4'h0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 12'h041, 32'hCAFEF00D, 4'h6, 1'b0, 1'b0, 4'h9, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 12'h040, 32'h00000000, 4'h0, 1'b0, 1'b1, 4'hF, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 12'h041, 32'h00000000, 4'h3, 1'b0, 1'b1, 4'hF, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 12'h042, 32'h55AA55AA, 4'hA, 1'b1, 1'b0, 4'h5, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 12'h7FF, 32'h00000000, 4'h0, 1'b0, 1'b1, 4'hF, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 12'hFFF, 32'hFFFFFFFF, 4'h8, 1'b0, 1'b0, 4'h7, 1'b1};

    // Reset state, with a request already offered.
    to_neg();
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_mem_cen", 64'(mem_cen), 64'(1));
    check("rst_mem_initn", 64'(mem_initn), 64'(0));
    to_pos();
    to_neg();
    to_pos();
    RST = 1'b0;

    // First cycle after release: still initialising.
    to_neg();
    check("init_initn", 64'(mem_initn), 64'(0));
    check("init_ready", 64'(req_ready), 64'(0));
    check("init_cen", 64'(mem_cen), 64'(1));
    to_pos();
    to_neg();
    check("run_initn", 64'(mem_initn), 64'(1));
    check("run_ready", 64'(req_ready), 64'(1));
    check("run_cen", 64'(mem_cen), 64'(0));
    to_pos();
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].be);
      to_neg();
      check("vec_cen", 64'(mem_cen), 64'(vecs[i].cen));
      check("vec_wen", 64'(mem_wen), 64'(vecs[i].wen));
      check("vec_ben", 64'(mem_ben), 64'(vecs[i].ben));
      check("vec_ready", 64'(req_ready), 64'(vecs[i].rdy));
      check("vec_addr", 64'(mem_a), 64'(vecs[i].a));
      check("vec_wdata", 64'(mem_d), 64'(vecs[i].d));
      to_pos();
    end
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin to_neg(); to_pos(); end

    do_write(12'h010, 32'hDEADBEEF, 4'hF);
    read_expect(12'h010, 32'hDEADBEEF, "full_word");

    do_write(12'h020, 32'hAABBCCDD, 4'hF);
    do_write(12'h020, 32'h11223344, 4'h5);
    read_expect(12'h020, 32'hAA22CC44, "byte_en");

    // Backpressure: two reads fit, the third waits for a pop.
    g_chk_lat = 1'b0;
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 12'h100, 32'h0, 4'h0);
    to_neg();
    check("bp_ready0", 64'(req_ready), 64'(1));
    to_pos();
    drive(1'b1, 1'b0, 12'h101, 32'h0, 4'h0);
    to_neg();
    check("bp_ready1", 64'(req_ready), 64'(1));
    to_pos();
    drive(1'b1, 1'b0, 12'h102, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      to_neg();
      check("bp_stall_ready", 64'(req_ready), 64'(0));
      check("bp_stall_cen", 64'(mem_cen), 64'(1));
      check("bp_hold_valid", 64'(rsp_valid), 64'(1));
      check("bp_hold_data", 64'(rsp_rdata), 64'(pat(12'h100)));
      to_pos();
    end
    rsp_ready = 1'b1;
    to_neg();
    check("bp_pop_ready", 64'(req_ready), 64'(1));
    to_pos();
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin to_neg(); to_pos(); end
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // Streaming reads: scoreboard latency of 2 on every response means no bubbles.
    g_chk_lat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 12'h200 + 12'(i), 32'h0, 4'h0);
      to_neg();
      check("stream_ready", 64'(req_ready), 64'(1));
      to_pos();
    end
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin to_neg(); to_pos(); end
    check("stream_drained", 64'(exp_q.size()), 64'(0));

    // Reset while a read is in flight (d=0) or buffered (d=1).
    for (int d = 0; d < 2; d++) begin
      drive(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
      to_neg();
      to_pos();
      drive(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
      if (d == 1) begin
        to_neg();
        to_pos();
      end
      RST = 1'b1;
      exp_q.delete();
      to_neg();
      check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("midrst_ready", 64'(req_ready), 64'(0));
      to_pos();
      to_neg();
      to_pos();
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
        to_neg();
        check("postrst_no_rsp", 64'(rsp_valid), 64'(0));
        to_pos();
      end
    end

    check("final_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
